// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding,
// default operand width and the bit-counter width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must index bits 0..width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/bit_serial_adder_fulladder.sv
// Existing one-bit full-adder cell used as the arithmetic core of the
// bit-serial adder.
module fulladder (
    output logic s,
    output logic c,
    input  logic a,
    input  logic b,
    input  logic cin
);

    assign s = a ^ b ^ cin;
    assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder around a single full-adder cell.
// Optional subtract support is enabled by defining SERIAL_ADDER_SUB_EN.
module bit_serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output state_t           dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid is held until that edge and ready never depends
    // combinationally on valid.

    localparam int                 CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, sum_q;
    logic [WIDTH-1:0]   b_load;
    logic               carry_q, carry_load;
    logic               cout_q, ovf_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               fa_s, fa_c;
    logic               last;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: invert B and inject a carry of one.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub | cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    fulladder u_fa (
        .s   (fa_s),
        .c   (fa_c),
        .a   (a_q[0]),
        .b   (b_q[0]),
        .cin (carry_q)
    );

    assign last      = (cnt_q == LAST_CNT);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = SHIFT;
            SHIFT:   if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b_load;
                        carry_q <= carry_load;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= fa_c;
                    // Counter parks at its terminal value instead of wrapping.
                    if (last) begin
                        cout_q <= fa_c;
                        ovf_q  <= carry_q ^ fa_c;
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8 and WIDTH=2 instances)
// against an arithmetic reference model; honours SERIAL_ADDER_SUB_EN.
module tb_bit_serial_adder;
    import serial_adder_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- WIDTH=8 instance ----------------
    logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [7:0] a = '0, b = '0, sum;
    logic       cin = 1'b0, sub = 1'b0, cout, ovf;
    state_t     dbg_state;

    bit_serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .dbg_state(dbg_state)
    );

    // ---------------- WIDTH=2 instance ----------------
    logic       v2 = 1'b0, rdy2, ov2, or2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0, s2;
    logic       cin2 = 1'b0, sub2 = 1'b0, co2, ovf2;
    state_t     st2;

    bit_serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2),
        .a(a2), .b(b2), .cin(cin2),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub2),
`endif
        .out_valid(ov2), .out_ready(or2),
        .sum(s2), .cout(co2), .ovf(ovf2), .dbg_state(st2)
    );

    // ---------------- scoreboard ----------------
    logic [33:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer addition; returns {ovf, cout, sum[31:0]}.
    function automatic logic [33:0] ref_add(input int w, input logic [31:0] x, input logic [31:0] y,
                                            input logic ci, input logic sb);
        logic [63:0] mask, aa, bb, r;
        logic c0, v;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'b0, x} & mask;
        bb   = (sb ? ~{32'b0, y} : {32'b0, y}) & mask;
        c0   = sb ? 1'b1 : ci;
        r    = aa + bb + {63'b0, c0};
        v    = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
        return {v, r[w], r[31:0] & mask[31:0]};
    endfunction

    // ---------------- drivers (WIDTH=8) ----------------
    task automatic wait_done();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency8", 64'(n), 64'd8);
    endtask

    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic tcin, input logic tsub);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        @(negedge clk);
        a = ta; b = tb; cin = tcin; in_valid = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub = tsub;
`else
        sub = 1'b0;
`endif
        @(posedge clk);
        exp_q.push_back(ref_add(8, {24'b0, ta}, {24'b0, tb}, tcin, sub));
        #1 in_valid = 1'b0;
        wait_done();
    endtask

    task automatic finish_op(input int hold);
        logic [33:0] e;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check("result8", {30'b0, ovf, cout, 24'b0, sum}, {30'b0, e});
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        check("handoff_idle", 64'(dbg_state), 64'(IDLE));
    endtask

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tcin, input logic tsub);
        start_op(ta, tb, tcin, tsub);
        finish_op(0);
    endtask

    // ---------------- driver (WIDTH=2) ----------------
    task automatic op2(input logic [1:0] ta, input logic [1:0] tb, input logic tcin, input logic tsub);
        int n;
        logic [33:0] e;
        @(negedge clk);
        a2 = ta; b2 = tb; cin2 = tcin; v2 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub2 = tsub;
`else
        sub2 = 1'b0;
`endif
        @(posedge clk);
        e = ref_add(2, {30'b0, ta}, {30'b0, tb}, tcin, sub2);
        #1 v2 = 1'b0;
        n = 0;
        while (!ov2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency2", 64'(n), 64'd2);
        check("result2", {30'b0, ovf2, co2, 30'b0, s2}, {30'b0, e});
        or2 = 1'b1;
        @(posedge clk); #1 or2 = 1'b0;
        check("idle2", 64'(rdy2), 64'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [33:0] e;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_result", {61'b0, ovf, cout, 1'b0} | 64'(sum), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        do_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        check("hold_5a3c", {62'b0, ovf, cout} << 8 | 64'(sum), 64'h296);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        check("hold_ff01", {62'b0, ovf, cout} << 8 | 64'(sum), 64'h100);
        do_op(8'h7F, 8'h00, 1'b1, 1'b0);
        check("hold_7f00", {62'b0, ovf, cout} << 8 | 64'(sum), 64'h280);
`ifdef SERIAL_ADDER_SUB_EN
        do_op(8'h10, 8'h20, 1'b0, 1'b1);
        check("sub_1020", {62'b0, ovf, cout} << 8 | 64'(sum), 64'h0F0);
        do_op(8'h80, 8'h01, 1'b0, 1'b1);
        check("sub_8001", {62'b0, ovf, cout} << 8 | 64'(sum), 64'h37F);
`endif

        // Backpressure in DONE while new operands are offered.
        start_op(8'h33, 8'h44, 1'b0, 1'b0);
        e = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = 8'($urandom); b = 8'($urandom); in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_stable", {30'b0, ovf, cout, 24'b0, sum}, {30'b0, e});
        end
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        finish_op(0);
        @(posedge clk);
        exp_q.push_back(ref_add(8, 32'h11, 32'h22, 1'b0, 1'b0));
        #1 in_valid = 1'b0;
        check("bp_accept_after", 64'(dbg_state), 64'(SHIFT));
        wait_done();
        finish_op(0);

        // Reset after three SHIFT edges.
        @(negedge clk);
        a = 8'hC3; b = 8'h5A; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_sum", 64'(sum), 64'd0);
        check("rst_mid_state", 64'(dbg_state), 64'(IDLE));
        @(negedge clk); rst_n = 1'b1;
        do_op(8'h12, 8'h34, 1'b0, 1'b0);
        check("post_rst", {63'b0, cout} << 8 | 64'(sum), 64'h046);

        // Randomized traffic with random consumer stalls.
        for (int i = 0; i < 40; i++) begin
            start_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            finish_op($urandom_range(0, 3));
        end

        // WIDTH=2 boundary: spot value then exhaustive sweep.
        op2(2'h3, 2'h1, 1'b1, 1'b0);
        check("w2_spot", {62'b0, ovf2, co2} << 2 | 64'(s2), 64'h5);
        for (int i = 0; i < 64; i++) begin
            op2(2'(i), 2'(i >> 2), 1'(i >> 4), 1'(i >> 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
